quad_encoder_tx: RTL and testbench



---
 rtl/pong_pkg.sv | 17 +
 rtl/dwell_timer.sv | 27 ++
 rtl/quad_encoder_tx.sv | 126 ++++++++++++
 tb/tb_quad_encoder_tx.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pong_pkg.sv
// Shared types and constants for the pong encoder/paddle blocks.
package pong_pkg;

   localparam int unsigned POS_W = 6;

   typedef enum logic {DIR_UP, DIR_DN} dir_e;
   typedef enum logic {ST_IDLE, ST_STEP} state_e;

   // {a,b} levels per phase; A leads going up, B leads going down
   localparam logic [1:0] PH_UP [0:3] = '{2'b10, 2'b11, 2'b01, 2'b00};
   localparam logic [1:0] PH_DN [0:3] = '{2'b01, 2'b11, 2'b10, 2'b00};

   function automatic logic [1:0] phase_level(input dir_e dir, input logic [1:0] ph);
      return (dir == DIR_UP) ? PH_UP[ph] : PH_DN[ph];
   endfunction

endpackage

// File: rtl/dwell_timer.sv
// DWELL-cycle down-counter: start loads it, expire_c_o is high once it has run out.
module dwell_timer #(
   parameter int unsigned DWELL = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic start_i,
   output logic expire_c_o
);

   localparam int unsigned CNT_W = $clog2(DWELL + 1);

   logic [CNT_W-1:0] count_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count_q <= '0;
      end else if (start_i) begin
         count_q <= CNT_W'(DWELL - 1);
      end else if (count_q != '0) begin
         count_q <= count_q - CNT_W'(1);
      end
   end

   assign expire_c_o = (count_q == '0);

endmodule

// File: rtl/quad_encoder_tx.sv
// Quadrature emitter: walks pos toward a commanded target one full
// 4-phase Gray cycle per unit, driving enc_a/enc_b.
module quad_encoder_tx
   import pong_pkg::*;
#(
   parameter int unsigned      DWELL    = 4,
   parameter logic [POS_W-1:0] HOME_POS = 6'd28
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             cmd_valid,
   input  logic [POS_W-1:0] cmd_target,
   output logic             cmd_ready,
   input  logic             abort,
   input  logic             home,
   output logic             enc_a,
   output logic             enc_b,
   output logic [POS_W-1:0] pos,
   output logic             busy,
   output logic             done
);

   state_e           state_q;
   dir_e             dir_q;
   logic [1:0]       phase_q;
   logic [POS_W-1:0] pos_q;
   logic [POS_W-1:0] tgt_q;
   logic             abort_q;
   logic             zero_pend_q;
   logic [1:0]       enc_q;
   logic             busy_q;
   logic             done_q;
   logic             ready_q;

   logic expire_c;
   logic accept_c;
   logic finish_c;
   logic tmr_start_c;
   dir_e acc_dir_c;
   dir_e cont_dir_c;

   assign accept_c   = (state_q == ST_IDLE) && cmd_valid && !home;
   assign acc_dir_c  = (cmd_target > pos_q) ? DIR_UP : DIR_DN;
   assign cont_dir_c = (tgt_q > pos_q) ? DIR_UP : DIR_DN;
   // pos_q already reflects this step: it moved on entry to phase 3
   assign finish_c   = (state_q == ST_STEP) && expire_c && (phase_q == 2'd3) &&
                       ((pos_q == tgt_q) || abort_q || abort);
   assign tmr_start_c = (accept_c && (cmd_target != pos_q)) ||
                        ((state_q == ST_STEP) && expire_c && !finish_c);

   dwell_timer #(.DWELL(DWELL)) u_dwell (
      .clk        (clk),
      .reset      (reset),
      .start_i    (tmr_start_c),
      .expire_c_o (expire_c)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         dir_q       <= DIR_UP;
         phase_q     <= 2'd0;
         pos_q       <= HOME_POS;
         tgt_q       <= HOME_POS;
         abort_q     <= 1'b0;
         zero_pend_q <= 1'b0;
         enc_q       <= 2'b00;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         ready_q     <= 1'b1;
      end else begin
         done_q      <= zero_pend_q;
         zero_pend_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (home) begin
                  pos_q <= HOME_POS;
               end else if (cmd_valid) begin
                  if (cmd_target == pos_q) begin
                     zero_pend_q <= 1'b1;
                  end else begin
                     state_q <= ST_STEP;
                     tgt_q   <= cmd_target;
                     dir_q   <= acc_dir_c;
                     phase_q <= 2'd0;
                     enc_q   <= phase_level(acc_dir_c, 2'd0);
                     abort_q <= 1'b0;
                     busy_q  <= 1'b1;
                     ready_q <= 1'b0;
                  end
               end
            end
            default: begin
               if (abort) abort_q <= 1'b1;
               if (expire_c) begin
                  if (phase_q == 2'd2) begin
                     pos_q <= (dir_q == DIR_UP) ? pos_q + POS_W'(1) : pos_q - POS_W'(1);
                  end
                  if (phase_q != 2'd3) begin
                     phase_q <= phase_q + 2'd1;
                     enc_q   <= phase_level(dir_q, phase_q + 2'd1);
                  end else if (finish_c) begin
                     state_q <= ST_IDLE;
                     abort_q <= 1'b0;
                     busy_q  <= 1'b0;
                     ready_q <= 1'b1;
                     done_q  <= 1'b1;
                  end else begin
                     dir_q   <= cont_dir_c;
                     phase_q <= 2'd0;
                     enc_q   <= phase_level(cont_dir_c, 2'd0);
                  end
               end
            end
         endcase
      end
   end

   assign enc_a     = enc_q[1];
   assign enc_b     = enc_q[0];
   assign pos       = pos_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign cmd_ready = ready_q;

endmodule

// File: tb/tb_quad_encoder_tx.sv
// Bench for quad_encoder_tx: directed scenarios plus random traffic
// checked every cycle against a cycle-count based behavioural model.
module tb_quad_encoder_tx;

   localparam int         D  = 2;
   localparam logic [5:0] HP = 6'd28;

   logic       clk = 1'b0;
   logic       reset;
   logic       cmd_valid;
   logic [5:0] cmd_target;
   logic       cmd_ready;
   logic       abort;
   logic       home;
   logic       enc_a;
   logic       enc_b;
   logic [5:0] pos;
   logic       busy;
   logic       done;

   int total = 0;
   int bad   = 0;
   bit cmp_en = 1'b0;

   quad_encoder_tx #(.DWELL(D), .HOME_POS(HP)) dut (
      .clk        (clk),
      .reset      (reset),
      .cmd_valid  (cmd_valid),
      .cmd_target (cmd_target),
      .cmd_ready  (cmd_ready),
      .abort      (abort),
      .home       (home),
      .enc_a      (enc_a),
      .enc_b      (enc_b),
      .pos        (pos),
      .busy       (busy),
      .done       (done)
   );

   always #5 clk = ~clk;

   logic [1:0] up_tab [4] = '{2'b10, 2'b11, 2'b01, 2'b00};
   logic [1:0] dn_tab [4] = '{2'b01, 2'b11, 2'b10, 2'b00};

   // Model: a command is a cycle count tc since acceptance; phase = tc/D within a 4*D step
   bit m_busy, m_up, m_abort, m_done, m_zpend;
   int m_pos, m_tgt, m_tc;

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         m_busy = 0; m_up = 1; m_abort = 0; m_done = 0; m_zpend = 0;
         m_pos = int'(HP); m_tgt = int'(HP); m_tc = 0;
      end else begin
         m_done = 0;
         if (!m_busy) begin
            if (m_zpend) m_done = 1;
            m_zpend = 0;
            if (home) m_pos = int'(HP);
            else if (cmd_valid) begin
               if (int'(cmd_target) == m_pos) m_zpend = 1;
               else begin
                  m_busy = 1; m_tgt = int'(cmd_target); m_up = (m_tgt > m_pos);
                  m_tc = 0; m_abort = 0;
               end
            end
         end else begin
            if (abort) m_abort = 1;
            m_tc++;
            if (m_tc == 3 * D) m_pos = m_up ? m_pos + 1 : m_pos - 1;
            if (m_tc == 4 * D) begin
               if (m_pos == m_tgt || m_abort) begin
                  m_busy = 0; m_done = 1;
               end else begin
                  m_tc = 0; m_up = (m_tgt > m_pos);
               end
            end
         end
      end
   end

   always @(negedge clk) begin
      logic [1:0] exp_ab;
      if (cmp_en) begin
         exp_ab = m_busy ? (m_up ? up_tab[m_tc / D] : dn_tab[m_tc / D]) : 2'b00;
         total++;
         if ({enc_a, enc_b} !== exp_ab || pos !== 6'(m_pos) || busy !== m_busy ||
             cmd_ready !== !m_busy || done !== m_done) begin
            bad++;
            $display("FAIL model t=%0t ab=%b/%b pos=%0d/%0d busy=%b/%b rdy=%b/%b done=%b/%b (got/exp)",
                     $time, {enc_a, enc_b}, exp_ab, pos, m_pos, busy, m_busy,
                     cmd_ready, !m_busy, done, m_done);
         end
      end
   end

   task automatic chk(input string nm, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   // Returns at the negedge just after the acceptance edge E0
   task automatic issue(input logic [5:0] t);
      @(negedge clk);
      cmd_valid = 1'b1; cmd_target = t;
      @(negedge clk);
      cmd_valid = 1'b0;
   endtask

   task automatic do_home();
      @(negedge clk);
      home = 1'b1;
      @(negedge clk);
      home = 1'b0;
   endtask

   logic [1:0] seq30 [16] = '{2'b10, 2'b10, 2'b11, 2'b11, 2'b01, 2'b01, 2'b00, 2'b00,
                              2'b10, 2'b10, 2'b11, 2'b11, 2'b01, 2'b01, 2'b00, 2'b00};
   logic [1:0] seq27 [8]  = '{2'b01, 2'b01, 2'b11, 2'b11, 2'b10, 2'b10, 2'b00, 2'b00};

   initial begin
      int n;
      int t;
      reset = 1'b1; cmd_valid = 1'b0; cmd_target = '0; home = 1'b0; abort = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      cmp_en = 1'b1;

      chk("rst_pos", int'(pos), 28);
      chk("rst_ab", int'({enc_a, enc_b}), 0);
      chk("rst_rdy", int'(cmd_ready), 1);
      chk("rst_done", int'(done), 0);

      // two steps up
      issue(6'd30);
      for (int k = 0; k < 16; k++) begin
         chk("t30_ab", int'({enc_a, enc_b}), int'(seq30[k]));
         chk("t30_busy", int'(busy), 1);
         if (k == 5)  chk("t30_pos5", int'(pos), 28);
         if (k == 6)  chk("t30_pos6", int'(pos), 29);
         if (k == 13) chk("t30_pos13", int'(pos), 29);
         if (k == 14) chk("t30_pos14", int'(pos), 30);
         tick();
      end
      chk("t30_done", int'(done), 1);
      chk("t30_idle", int'(busy), 0);
      tick();
      chk("t30_done_pulse", int'(done), 0);

      // one step down
      do_home();
      chk("home_pos", int'(pos), 28);
      issue(6'd27);
      for (int k = 0; k < 8; k++) begin
         chk("t27_ab", int'({enc_a, enc_b}), int'(seq27[k]));
         if (k == 5) chk("t27_pos5", int'(pos), 28);
         if (k == 6) chk("t27_pos6", int'(pos), 27);
         tick();
      end
      chk("t27_done", int'(done), 1);

      // zero-step command
      do_home();
      issue(6'd28);
      chk("t28_done0", int'(done), 0);
      chk("t28_busy0", int'(busy), 0);
      tick();
      chk("t28_done1", int'(done), 1);
      chk("t28_ab", int'({enc_a, enc_b}), 0);
      tick();
      chk("t28_done2", int'(done), 0);

      // abort mid-step, then back-to-back command held on the done cycle
      issue(6'd40);
      tick(); tick();
      abort = 1'b1;
      tick();
      abort = 1'b0;
      repeat (4) tick();
      cmd_valid = 1'b1; cmd_target = 6'd31;
      tick();
      chk("abort_done", int'(done), 1);
      chk("abort_pos", int'(pos), 29);
      chk("abort_rdy", int'(cmd_ready), 1);
      tick();
      chk("b2b_busy", int'(busy), 1);
      chk("b2b_ab", int'({enc_a, enc_b}), 2);
      cmd_valid = 1'b0;
      home = 1'b1;
      tick();
      home = 1'b0;
      n = 0;
      while (!done && n < 100) begin
         tick();
         n++;
      end
      chk("b2b_done_seen", int'(done), 1);
      chk("busy_home_ignored", int'(pos), 31);

      // home wins over a simultaneous command
      home = 1'b1; cmd_valid = 1'b1; cmd_target = 6'd10;
      tick();
      home = 1'b0; cmd_valid = 1'b0;
      chk("home_cmd_pos", int'(pos), 28);
      chk("home_cmd_busy", int'(busy), 0);
      tick();
      chk("home_cmd_done", int'(done), 0);

      // reset in the middle of a step
      issue(6'd35);
      repeat (3) tick();
      #1 reset = 1'b1;
      #1;
      chk("mid_rst_ab", int'({enc_a, enc_b}), 0);
      chk("mid_rst_pos", int'(pos), 28);
      chk("mid_rst_rdy", int'(cmd_ready), 1);
      chk("mid_rst_done", int'(done), 0);
      repeat (5) tick();
      reset = 1'b0;

      // random traffic
      repeat (5000) begin
         @(negedge clk);
         cmd_valid = ($urandom_range(0, 3) == 0);
         if ($urandom_range(0, 3) == 0) t = int'($urandom_range(0, 63));
         else t = m_pos + int'($urandom_range(0, 8)) - 4;
         if (t < 0) t = 0;
         if (t > 63) t = 63;
         cmd_target = 6'(t);
         abort = ($urandom_range(0, 40) == 0);
         home  = ($urandom_range(0, 15) == 0);
         if ($urandom_range(0, 700) == 0) begin
            #2 reset = 1'b1;
            @(negedge clk);
            reset = 1'b0;
         end
      end
      @(negedge clk);
      cmd_valid = 1'b0; abort = 1'b0; home = 1'b0;
      repeat (3) @(negedge clk);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
